// File: rtl/vid_mem_resp.sv
// Video-bus target holding a word-addressed frame-buffer RAM.
// Serves burst reads after a fixed latency and a bus grant, and burst writes that end in a one-cycle response.
module vid_mem_resp #(
  parameter int          AW     = 10,
  parameter int          RD_LAT = 2,
  parameter logic [3:0]  TAR_ID = 4'h1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        selin,
  input  logic [2:0]  cmdin,
  input  logic [1:0]  lenin,
  input  logic [31:0] addrdatain,
  input  logic        ackin,
  output logic [1:0]  reqout,
  output logic [3:0]  reqtar,
  output logic [1:0]  lenout,
  output logic [2:0]  cmdout,
  output logic [31:0] addrdataout,
  output logic        busy
);

  // state   | meaning
  // IDLE    | waiting for a read or write request
  // RD_WAIT | read accepted, counting out the read latency
  // RD_BID  | bidding for the bus to return read data
  // RD_DATA | driving read data beats
  // WR_DATA | accepting write data beats (gaps allowed)
  // WR_BID  | bidding for the bus to send the write response
  // WR_RESP | driving the single write-response cycle
  typedef enum logic [2:0] {
    IDLE, RD_WAIT, RD_BID, RD_DATA, WR_DATA, WR_BID, WR_RESP
  } state_t;

  localparam logic [2:0] CMD_WDATA = 3'b001;
  localparam logic [2:0] CMD_RDREQ = 3'b010;
  localparam logic [2:0] CMD_RDATA = 3'b011;
  localparam logic [2:0] CMD_WRREQ = 3'b100;
  localparam logic [2:0] CMD_WRSP  = 3'b101;
  localparam logic [3:0] WAIT_LOAD = 4'(RD_LAT) - 4'd1;

  logic [31:0] mem [0:2**AW-1];

  state_t          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [1:0]      len_q, len_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [2:0]      beat_q, beat_d;
  logic [3:0]      wait_q, wait_d;
  logic [2:0]      last_beat;
  logic [AW-1:0]   rd_idx;
  logic            wr_en;
  logic            bid_d;
  logic [2:0]      cmdout_d;
  logic [1:0]      lenout_d;

  always_comb begin
    case (len_q)
      2'b00:   last_beat = 3'd0;
      2'b01:   last_beat = 3'd1;
      2'b10:   last_beat = 3'd3;
      default: last_beat = 3'd7;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    idx_d   = idx_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (selin && (cmdin == CMD_RDREQ || cmdin == CMD_WRREQ)) begin
          addr_d = addrdatain;
          len_d  = lenin;
          idx_d  = addrdatain[AW+1:2];
          beat_d = '0;
          wait_d = WAIT_LOAD;
          if (cmdin == CMD_WRREQ)
            state_d = WR_DATA;
          else
            state_d = (RD_LAT == 0) ? RD_BID : RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (wait_q == 4'd0)
          state_d = RD_BID;
        else
          wait_d = wait_q - 4'd1;
      end
      RD_BID: begin
        if (ackin)
          state_d = RD_DATA;
      end
      RD_DATA: begin
        if (beat_q == last_beat) begin
          state_d = IDLE;
        end else begin
          beat_d = beat_q + 3'd1;
          idx_d  = idx_q + AW'(1);
        end
      end
      WR_DATA: begin
        if (cmdin == CMD_WDATA) begin
          wr_en = 1'b1;
          idx_d = idx_q + AW'(1);
          if (beat_q == last_beat)
            state_d = WR_BID;
          else
            beat_d = beat_q + 3'd1;
        end
      end
      WR_BID: begin
        if (ackin)
          state_d = WR_RESP;
      end
      WR_RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    bid_d    = (state_d == RD_BID) || (state_d == RD_DATA) ||
               (state_d == WR_BID) || (state_d == WR_RESP);
    cmdout_d = 3'b000;
    lenout_d = 2'b00;
    if (state_d == RD_DATA) begin
      cmdout_d = CMD_RDATA;
      lenout_d = len_d;
    end else if (state_d == WR_RESP) begin
      cmdout_d = CMD_WRSP;
    end
    // idx_q already points at the current beat while in RD_DATA, so fetch the following word
    rd_idx = (state_q == RD_DATA) ? idx_q + AW'(1) : idx_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      beat_q      <= '0;
      wait_q      <= '0;
      reqout      <= '0;
      reqtar      <= '0;
      lenout      <= '0;
      cmdout      <= '0;
      addrdataout <= '0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      beat_q      <= beat_d;
      wait_q      <= wait_d;
      reqout      <= bid_d ? 2'b11 : 2'b00;
      reqtar      <= bid_d ? TAR_ID : 4'h0;
      lenout      <= lenout_d;
      cmdout      <= cmdout_d;
      busy        <= (state_d != IDLE);
      if (state_d == RD_DATA)
        addrdataout <= mem[rd_idx];
      else if (state_d == WR_RESP)
        addrdataout <= addr_q;
      else
        addrdataout <= '0;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en && !reset)
      mem[idx_q] <= addrdatain;
  end

endmodule

// File: tb/tb_vid_mem_resp.sv
// Directed bench for vid_mem_resp: a word-array memory model plus per-cycle expected outputs,
// checked on every falling edge, with literal checks on captured read data.
module tb_vid_mem_resp;
  localparam int         AW     = 10;
  localparam int         RD_LAT = 2;
  localparam logic [3:0] TAR    = 4'h1;

  logic        clk = 1'b0;
  logic        reset;
  logic        selin;
  logic [2:0]  cmdin;
  logic [1:0]  lenin;
  logic [31:0] addrdatain;
  logic        ackin;
  logic [1:0]  reqout;
  logic [3:0]  reqtar;
  logic [1:0]  lenout;
  logic [2:0]  cmdout;
  logic [31:0] addrdataout;
  logic        busy;

  vid_mem_resp #(.AW(AW), .RD_LAT(RD_LAT), .TAR_ID(TAR)) dut (
    .clk(clk), .reset(reset), .selin(selin), .cmdin(cmdin), .lenin(lenin),
    .addrdatain(addrdatain), .ackin(ackin), .reqout(reqout), .reqtar(reqtar),
    .lenout(lenout), .cmdout(cmdout), .addrdataout(addrdataout), .busy(busy)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] mdl [0:2**AW-1];
  logic        chk_en = 1'b0;
  logic [1:0]  e_req;
  logic [3:0]  e_tar;
  logic [1:0]  e_len;
  logic [2:0]  e_cmd;
  logic [31:0] e_data;
  logic        e_busy;
  logic [31:0] rd_cap [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("reqout", 32'(reqout), 32'(e_req));
      chk("reqtar", 32'(reqtar), 32'(e_tar));
      chk("lenout", 32'(lenout), 32'(e_len));
      chk("cmdout", 32'(cmdout), 32'(e_cmd));
      chk("addrdataout", addrdataout, e_data);
      chk("busy", 32'(busy), 32'(e_busy));
      if (cmdout == 3'b011) rd_cap.push_back(addrdataout);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    selin = 1'b0; cmdin = 3'b000; lenin = 2'b00; addrdatain = '0; ackin = 1'b0;
  endtask

  task automatic exp_set(input bit req, input logic [1:0] len, input logic [2:0] cmd,
                         input logic [31:0] data, input bit bsy);
    e_req  = req ? 2'b11 : 2'b00;
    e_tar  = req ? TAR : 4'h0;
    e_len  = len;
    e_cmd  = cmd;
    e_data = data;
    e_busy = bsy;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [1:0] len, input logic [31:0] base,
                          input int gap, input int ack_dly);
    int n;
    logic [AW-1:0] idx;
    n   = 1 << len;
    idx = addr[AW+1:2];
    cyc(); idle_in(); selin = 1'b1; cmdin = 3'b100; lenin = len; addrdatain = addr;
    exp_set(0, 2'b00, 3'b000, 32'h0, 0);
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        for (int g = 0; g < gap; g++) begin
          cyc(); idle_in(); ackin = 1'b1;
          exp_set(0, 2'b00, 3'b000, 32'h0, 1);
        end
      end
      cyc(); idle_in(); cmdin = 3'b001; addrdatain = base + 32'(k);
      mdl[idx + AW'(k)] = base + 32'(k);
      exp_set(0, 2'b00, 3'b000, 32'h0, 1);
    end
    for (int d = 0; d < ack_dly; d++) begin
      cyc(); idle_in();
      exp_set(1, 2'b00, 3'b000, 32'h0, 1);
    end
    cyc(); idle_in(); ackin = 1'b1;
    exp_set(1, 2'b00, 3'b000, 32'h0, 1);
    cyc(); idle_in();
    exp_set(1, 2'b00, 3'b101, addr, 1);
    cyc(); idle_in();
    exp_set(0, 2'b00, 3'b000, 32'h0, 0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [1:0] len, input int ack_dly,
                         input bit bid_req, input int rst_beat);
    int n;
    logic [AW-1:0] idx;
    n   = 1 << len;
    idx = addr[AW+1:2];
    cyc(); idle_in(); selin = 1'b1; cmdin = 3'b010; lenin = len; addrdatain = addr;
    exp_set(0, 2'b00, 3'b000, 32'h0, 0);
    for (int w = 0; w < RD_LAT; w++) begin
      // stray data beats and grants during the latency window must be ignored
      cyc(); idle_in(); cmdin = 3'b001; addrdatain = 32'hDEAD_BEEF; ackin = 1'b1;
      exp_set(0, 2'b00, 3'b000, 32'h0, 1);
    end
    for (int d = 0; d < ack_dly; d++) begin
      cyc(); idle_in();
      if (bid_req && d == 0) begin
        selin = 1'b1; cmdin = 3'b010; lenin = 2'b00; addrdatain = addr + 32'h40;
      end
      exp_set(1, 2'b00, 3'b000, 32'h0, 1);
    end
    cyc(); idle_in(); ackin = 1'b1;
    exp_set(1, 2'b00, 3'b000, 32'h0, 1);
    rd_cap.delete();
    for (int k = 0; k < n; k++) begin
      cyc(); idle_in();
      exp_set(1, len, 3'b011, mdl[idx + AW'(k)], 1);
      if (k == rst_beat) begin
        reset = 1'b1;
        cyc(); reset = 1'b0; idle_in();
        exp_set(0, 2'b00, 3'b000, 32'h0, 0);
        return;
      end
    end
    cyc(); idle_in();
    exp_set(0, 2'b00, 3'b000, 32'h0, 0);
  endtask

  initial begin
    reset = 1'b1;
    idle_in();
    exp_set(0, 2'b00, 3'b000, 32'h0, 0);
    repeat (2) cyc();
    chk_en = 1'b1;
    cyc();
    reset = 1'b0;

    // write then read, 4 beats
    do_write(32'h100, 2'b10, 32'hA0, 0, 3);
    do_read(32'h100, 2'b10, 1, 0, -1);
    chk("wr_rd_count", 32'(rd_cap.size()), 32'd4);
    chk("wr_rd_beat0", rd_cap[0], 32'h0000_00A0);
    chk("wr_rd_beat3", rd_cap[3], 32'h0000_00A3);

    // wrap-around across the top of the RAM
    do_write(32'hFF8, 2'b11, 32'hB0, 0, 0);
    do_read(32'hFF8, 2'b11, 0, 0, -1);
    chk("wrap_count", 32'(rd_cap.size()), 32'd8);
    chk("wrap_beat2", rd_cap[2], 32'h0000_00B2);
    chk("wrap_beat7", rd_cap[7], 32'h0000_00B7);
    do_read(32'h0000_4003, 2'b00, 0, 0, -1);
    chk("wrap_word0", rd_cap[0], 32'h0000_00B2);

    // gapped write: only 2 words land, neighbour untouched
    do_write(32'h208, 2'b00, 32'h55, 0, 0);
    do_write(32'h200, 2'b01, 32'hC0, 2, 0);
    do_read(32'h200, 2'b01, 0, 0, -1);
    chk("gap_beat1", rd_cap[1], 32'h0000_00C1);
    do_read(32'h208, 2'b00, 0, 0, -1);
    chk("gap_neighbour", rd_cap[0], 32'h0000_0055);

    // second request while bidding is dropped
    do_read(32'h100, 2'b10, 2, 1, -1);
    chk("busy_drop_count", 32'(rd_cap.size()), 32'd4);

    // long grant stall
    do_read(32'h200, 2'b01, 20, 0, -1);
    chk("stall_beat0", rd_cap[0], 32'h0000_00C0);

    // reset at beat 2 of 8, then RAM still holds the earlier write
    do_read(32'hFF8, 2'b11, 1, 0, 2);
    chk("rst_beats_seen", 32'(rd_cap.size()), 32'd3);
    do_read(32'hFF8, 2'b00, 0, 0, -1);
    chk("rst_after_read", rd_cap[0], 32'h0000_00B0);

    cyc();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vid_mem_resp.md
Name: vid_mem_resp

Overview:
- Bus target (responder) on the video bus. Services burst read requests issued by the video controller's pixel-fetch engine. Also services register-style single or burst writes.
- Holds a word-addressed frame-buffer RAM. Returns read data as consecutive data beats once the arbiter grants the bus.
- Sits on the target side of the arbiter, opposite the video controller.

Parameters:
- AW, 10, word-address width; RAM depth is 2**AW 32-bit words.
- RD_LAT, 2, idle cycles between accepting a read request and raising the bus bid (range 0-15).
- TAR_ID, 4'h1, value driven on reqtar while bidding or driving a response.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- selin  in  1  target select; a request is sampled only when selin=1
- cmdin  in  3  bus command: 000 idle, 001 write data, 010 read request, 100 write request
- lenin  in  2  burst length: 00=1, 01=2, 10=4, 11=8 beats
- addrdatain  in  32  byte address in the request cycle; data in 001 cycles
- ackin  in  1  arbiter grant for this block's bid
- reqout  out  2  bus bid: 11 = bidding, 00 = none
- reqtar  out  4  TAR_ID while reqout=11 or a response is driven, else 0
- lenout  out  2  echo of the latched lenin during a read response, else 0
- cmdout  out  3  011 read data beat, 101 write response, 000 otherwise
- addrdataout  out  32  read data, or start address on the write response, else 0
- busy  out  1  1 in any state other than IDLE

Behaviour:
- Reset:
  - All outputs are 0; state goes to IDLE; beat counter and latched addr/len clear.
  - RAM contents are not cleared.
  - Reset mid-burst aborts immediately; next cycle the outputs are idle.
- Addressing:
  - Word index = addr[AW+1:2]; addr[1:0] is ignored.
  - Upper address bits are ignored, because selin does the decode.
  - The word index increments by 1 per beat and wraps modulo 2**AW.
- Beat count N = 1 << lenin.
- IDLE:
  - selin=1 & cmdin=010: latch addr and len, then go to RD_WAIT (or RD_BID if RD_LAT=0).
  - selin=1 & cmdin=100: latch addr and len, clear the beat counter, go to WR_DATA.
  - Any other command: stay in IDLE.
- Requests while busy=1 are ignored, with no queueing.
- RD_WAIT: count RD_LAT cycles, then go to RD_BID.
- RD_BID:
  - reqout=11 and reqtar=TAR_ID.
  - Sample ackin each cycle; on ackin=1 go to RD_DATA.
  - Bid holds indefinitely with no timeout.
- RD_DATA:
  - Starts the cycle after the grant and runs for exactly N consecutive cycles.
  - Each cycle: cmdout=011, lenout=latched len, addrdataout=mem[idx+k] for beat k=0..N-1, reqout=11.
  - After beat N-1, next cycle: all outputs 0, state IDLE.
  - The implementation may prefetch from synchronous RAM during RD_BID. Externally visible timing is fixed as above.
- WR_DATA:
  - Each cycle with cmdin=001 writes addrdatain to mem[idx+k] and increments k.
  - Cycles with any other cmdin are gaps and are ignored; selin is not required in data cycles.
  - After the N-th write, go to WR_BID.
- WR_BID: reqout=11; on ackin=1 go to WR_RESP.
- WR_RESP:
  - One cycle: cmdout=101, addrdataout=latched start address, reqout=11.
  - Then return to IDLE.
- Read-after-write: a read issued after a write response returns the new data.
- Simultaneous events:
  - ackin=1 outside RD_BID or WR_BID is ignored.
  - A write data beat is not accepted outside WR_DATA.
- All outputs are registered. The only input-to-output dependency is through the state register.

Test Plan:
- Write then read, 4 beats: write req addr 0x100, len 10, data beats 0xA0..0xA3; ackin after 3 cycles -> cmdout=101 with addrdataout=0x100 for one cycle. Read addr 0x100 len 10, RD_LAT=2 -> reqout=11 three cycles after the request; ack -> 4 beats 0xA0,0xA1,0xA2,0xA3 with cmdout=011 and lenout=10, then idle.
- Wrap-around: with AW=10, write 8 beats at byte address 0xFF8 (words 1022..1029, wrapping to 0..5), then read 8 beats -> data order is exact and word 0 holds beat 2.
- Gapped write: data beats with two idle cycles between them, len 01 -> exactly 2 words written; the response follows only after the 2nd beat.
- Busy drop: a second read request while in RD_BID -> ignored; exactly one 4-beat response; busy falls after the last beat.
- Grant stall: withhold ackin for 20 cycles -> reqout stays 11, cmdout stays 000; data begins the cycle after ackin.
- Reset mid-burst: assert reset at beat 2 of 8 -> the next cycle all outputs are 0 and busy=0; a new single read returns the previously written word.
